uart_rx_framer: RTL and testbench

- Sequences the byte stream from the async UART receiver into validated command frames.
- Hunts for a sync byte, then captures a length byte, the payload and an XOR checksum into an internal single-frame buffer.
- On a good checksum, replays the payload to downstream command logic over a valid/ready stream.
- Uses the receiver's end-of-packet pulse as an inter-byte timeout that aborts partial frames.

---
 rtl/uart_framer_pkg.sv | 19 +
 rtl/framer_buf.sv | 22 ++
 rtl/uart_rx_framer.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_framer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_framer_pkg.sv
// Shared types and constants for the UART receive framer.
package uart_framer_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  localparam logic [1:0] ERR_CHK = 2'd0;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;
  localparam logic [1:0] ERR_OVR = 2'd3;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/framer_buf.sv
// Single-frame payload store: simple dual-port RAM, one write port, registered read.
module framer_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [DEPTH];

  // No reset on the array or read port so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/uart_rx_framer.sv
// Sync-hunting frame parser with XOR check and valid/ready payload replay.
// Optional counters enabled by defining UART_RX_FRAMER_STATS_EN.
module uart_rx_framer
  import uart_framer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int         MAX_LEN   = 16,
  parameter int         LW        = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          rx_ready,
  input  logic [7:0]    rx_data,
  input  logic          rx_eop,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_last,
  output logic [LW-1:0] out_len,
  output logic          frame_err,
  output logic [1:0]    err_code,
`ifdef UART_RX_FRAMER_STATS_EN
  input  logic          stats_clr,
  output logic [15:0]   good_cnt,
  output logic [15:0]   err_cnt,
  output logic [7:0]    ovr_cnt,
`endif
  output logic          busy
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e        state_q, st_byte;
  logic [LW-1:0] len_q, idx_q, rd_q, rd_d;
  logic [7:0]    chk_q;
  logic          out_valid_q, out_last_q, frame_err_q;
  logic [1:0]    err_code_q;
  logic          len_bad, idx_last, out_hs, tmo, buf_we;

  assign len_bad  = (rx_data == 8'd0) || (int'(rx_data) > MAX_LEN);
  assign idx_last = (idx_q == len_q - LW'(1));
  assign out_hs   = out_valid_q && out_ready;
  assign buf_we   = (state_q == PAYLOAD) && rx_ready;

  // The byte is consumed first; a coincident eop is judged against the resulting state.
  always_comb begin
    st_byte = state_q;
    if (rx_ready) begin
      case (state_q)
        HUNT:    if (rx_data == SYNC_BYTE) st_byte = LEN;
        LEN:     st_byte = len_bad ? HUNT : PAYLOAD;
        PAYLOAD: if (idx_last) st_byte = CHK;
        CHK:     st_byte = (rx_data == chk_q) ? DRAIN : HUNT;
        default: ;
      endcase
    end
    tmo = rx_eop && (st_byte inside {LEN, PAYLOAD, CHK});
  end

  // Read address tracks the byte on display, so out_data holds steady under backpressure.
  always_comb begin
    rd_d = rd_q;
    if (state_q == CHK)              rd_d = '0;
    else if (out_hs && !out_last_q)  rd_d = rd_q + LW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= HUNT;
      len_q       <= '0;
      idx_q       <= '0;
      rd_q        <= '0;
      chk_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_CHK;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        HUNT: if (rx_ready && rx_data == SYNC_BYTE) state_q <= LEN;
        LEN: if (rx_ready) begin
          if (len_bad) begin
            state_q     <= HUNT;
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_LEN;
          end else begin
            len_q   <= LW'(rx_data);
            chk_q   <= rx_data;
            idx_q   <= '0;
            state_q <= PAYLOAD;
          end
        end
        PAYLOAD: if (rx_ready) begin
          chk_q <= chk_q ^ rx_data;
          idx_q <= idx_q + LW'(1);
          if (idx_last) state_q <= CHK;
        end
        CHK: if (rx_ready) begin
          if (rx_data == chk_q) begin
            state_q     <= DRAIN;
            rd_q        <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= (len_q == LW'(1));
          end else begin
            state_q     <= HUNT;
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_CHK;
          end
        end
        DRAIN: begin
          if (rx_ready) begin
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_OVR;
          end
          if (out_hs) begin
            if (out_last_q) begin
              state_q     <= HUNT;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              rd_q       <= rd_d;
              out_last_q <= (rd_d == len_q - LW'(1));
            end
          end
        end
        default: state_q <= HUNT;
      endcase
      if (tmo) begin
        state_q     <= HUNT;
        frame_err_q <= 1'b1;
        err_code_q  <= ERR_TMO;
      end
    end
  end

  framer_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (idx_q[AW-1:0]),
    .wdata_i (rx_data),
    .raddr_i (rd_d[AW-1:0]),
    .rdata_o (out_data)
  );

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_len   = len_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != HUNT);

`ifdef UART_RX_FRAMER_STATS_EN
  logic [15:0] good_q, err_q;
  logic [7:0]  ovr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      good_q <= '0;
      err_q  <= '0;
      ovr_q  <= '0;
    end else if (stats_clr) begin
      good_q <= '0;
      err_q  <= '0;
      ovr_q  <= '0;
    end else begin
      if (out_hs && out_last_q && good_q != 16'hFFFF) good_q <= good_q + 16'd1;
      if (frame_err_q && err_code_q != ERR_OVR && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
      if (frame_err_q && err_code_q == ERR_OVR && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
    end
  end

  assign good_cnt = good_q;
  assign err_cnt  = err_q;
  assign ovr_cnt  = ovr_q;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed self-checking bench for uart_rx_framer (stats ports follow UART_RX_FRAMER_STATS_EN).
module tb_uart_rx_framer;

  localparam int MAX_LEN = 16;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic          clk = 1'b0, resetn = 1'b0;
  logic          rx_ready = 1'b0, rx_eop = 1'b0, out_ready = 1'b0, stats_clr = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          out_valid, out_last, frame_err, busy;
  logic [7:0]    out_data;
  logic [LW-1:0] out_len;
  logic [1:0]    err_code;
`ifdef UART_RX_FRAMER_STATS_EN
  logic [15:0]   good_cnt, err_cnt;
  logic [7:0]    ovr_cnt;
`endif

  uart_rx_framer #(.MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_eop    (rx_eop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_len   (out_len),
    .frame_err (frame_err),
    .err_code  (err_code),
`ifdef UART_RX_FRAMER_STATS_EN
    .stats_clr (stats_clr),
    .good_cnt  (good_cnt),
    .err_cnt   (err_cnt),
    .ovr_cnt   (ovr_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         n_run = 0, n_fail = 0;
  int         n_err = 0;
  logic [1:0] last_code = 2'd0;
  logic [7:0] q_data[$];
  logic       q_last[$];
  logic [7:0] pl[$];

  always @(negedge clk) begin
    if (frame_err) begin
      n_err++;
      last_code = err_code;
    end
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_last.push_back(out_last);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] n);
    logic [7:0] c;
    c = n;
    send_byte(8'hA5);
    send_byte(n);
    foreach (pl[i]) begin
      send_byte(pl[i]);
      c = c ^ pl[i];
    end
    send_byte(c);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((busy || out_valid) && k < 500) begin
      tick();
      k++;
    end
    check({tag, "_idle"}, 32'(k < 500), 32'd1);
    tick();
  endtask

  task automatic check_drain(input string tag, input int n);
    check({tag, "_cnt"}, q_data.size(), n);
    if (q_data.size() == n)
      foreach (pl[i]) begin
        check($sformatf("%s_d%0d", tag, i), q_data[i], pl[i]);
        check($sformatf("%s_l%0d", tag, i), q_last[i], 32'(i == n - 1));
      end
    q_data.delete();
    q_last.delete();
  endtask

  initial begin
    int  e0;
    bit  stable;

    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_last",  out_last,  0);
    check("rst_err",   frame_err, 0);
    check("rst_busy",  busy,      0);
    check("rst_len",   out_len,   0);
    check("rst_code",  err_code,  0);
    resetn = 1'b1;
    tick();

    // Good 3-byte frame, no backpressure
    out_ready = 1'b1;
    e0 = n_err;
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(8'd3);
    check("g3_first_vld",  out_valid, 1);
    check("g3_first_data", out_data,  8'h11);
    check("g3_len",        out_len,   3);
    wait_idle("g3");
    check_drain("g3", 3);
    check("g3_noerr", n_err - e0, 0);

    // Bad checksum, then a 1-byte good frame
    e0 = n_err;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'hFF);
    tick();
    check("badchk_err",  n_err - e0, 1);
    check("badchk_code", last_code,  0);
    check("badchk_busy", busy,       0);
    check("badchk_out",  q_data.size(), 0);
    pl = '{8'h7E};
    send_frame(8'd1);
    check("g1_last_first", out_last, 1);
    wait_idle("g1");
    check_drain("g1", 1);

    // Length bounds
    e0 = n_err;
    send_byte(8'hA5); send_byte(8'h00); tick();
    check("len0_err",  n_err - e0, 1);
    check("len0_code", last_code,  1);
    send_byte(8'hA5); send_byte(8'(MAX_LEN + 1)); tick();
    check("lenmax1_err",  n_err - e0, 2);
    check("lenmax1_code", last_code,  1);
    check("lenmax1_busy", busy,       0);
    pl.delete();
    for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'(i * 13 + 5));
    e0 = n_err;
    send_frame(8'(MAX_LEN));
    wait_idle("full");
    check_drain("full", MAX_LEN);
    check("full_noerr", n_err - e0, 0);

    // Garbage before sync, then timeout mid-payload
    e0 = n_err;
    send_byte(8'h00); send_byte(8'hFF); tick();
    check("garbage_err",  n_err - e0, 0);
    check("garbage_busy", busy,       0);
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    check("tmo_busy_pre", busy, 1);
    rx_eop = 1'b1; tick(); rx_eop = 1'b0; tick();
    check("tmo_err",  n_err - e0, 1);
    check("tmo_code", last_code,  2);
    check("tmo_busy", busy,       0);
    rx_eop = 1'b1; tick(); rx_eop = 1'b0; tick();
    check("eop_hunt_ignored", n_err - e0, 1);

    // Sync byte and eop in the same cycle: eop sees LEN
    rx_data = 8'hA5; rx_ready = 1'b1; rx_eop = 1'b1; tick();
    rx_ready = 1'b0; rx_eop = 1'b0; tick();
    check("simul_err",  n_err - e0, 2);
    check("simul_code", last_code,  2);
    check("simul_busy", busy,       0);

    // Backpressure plus overrun during drain
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    out_ready = 1'b0;
    e0 = n_err;
    pl = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(8'd3);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!out_valid || out_data !== 8'hAA) stable = 1'b0;
      tick();
    end
    check("bp_stable", 32'(stable), 1);
    send_byte(8'h55); tick();
    check("ovr_err",   n_err - e0, 1);
    check("ovr_code",  last_code,  3);
    check("ovr_data",  out_data,   8'hAA);
    check("ovr_valid", out_valid,  1);
    out_ready = 1'b1;
    wait_idle("bp");
    check_drain("bp", 3);
`ifdef UART_RX_FRAMER_STATS_EN
    check("stat_ovr",  ovr_cnt,  1);
    check("stat_good", good_cnt, 1);
    check("stat_err",  err_cnt,  0);
`endif

    // Async reset mid-payload
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h01);
    check("rp_busy_pre", busy, 1);
    #2 resetn = 1'b0;
    #1;
    check("rp_busy", busy,      0);
    check("rp_err",  frame_err, 0);
    check("rp_len",  out_len,   0);
    check("rp_code", err_code,  0);
    tick(); resetn = 1'b1; tick();

    // Async reset mid-drain drops out_valid immediately
    out_ready = 1'b0;
    pl = '{8'h5A, 8'h6B};
    send_frame(8'd2);
    check("rd_vld_pre", out_valid, 1);
    #2 resetn = 1'b0;
    #1;
    check("rd_vld",  out_valid, 0);
    check("rd_last", out_last,  0);
    check("rd_busy", busy,      0);
    tick(); resetn = 1'b1; tick();
    q_data.delete();
    q_last.delete();

    // Fresh frame after reset
    out_ready = 1'b1;
    e0 = n_err;
    pl = '{8'hC3, 8'h3C};
    send_frame(8'd2);
    check("post_len", out_len, 2);
    wait_idle("post");
    check_drain("post", 2);
    check("post_noerr", n_err - e0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
